// File: rtl/npu_pkg.sv
// npu_pkg: shared defaults, FSM encoding and pipeline tag type for the npu MAC sequencer
package npu_pkg;
  localparam int NPU_DATA_WIDTH = 8;
  localparam int NPU_FRAC_BITS  = 5;
  localparam int MAC_LATENCY    = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic start;
    logic last;
    logic valid;
  } tag_t;
endpackage

// File: rtl/npu_mac_seq_if.sv
// npu_mac_seq_if: layer control, weight/activation read ports, MAC stream and result port of the sequencer
interface npu_mac_seq_if #(
  parameter int DW   = 8,
  parameter int W_AW = 7,
  parameter int A_AW = 4,
  parameter int R_AW = 3
);
  logic            start;
  logic            busy;
  logic            done;
  logic            w_rd_en;
  logic [W_AW-1:0] w_addr;
  logic [DW-1:0]   w_data;
  logic            a_rd_en;
  logic [A_AW-1:0] a_addr;
  logic [DW-1:0]   a_data;
  logic            mac_en;
  logic            start_p;
  logic            last_p;
  logic [DW-1:0]   weight_out;
  logic [DW-1:0]   act_out;
  logic [DW-1:0]   mac_out_in;
  logic            mac_valid_in;
  logic            mac_overflow_in;
  logic            res_we;
  logic [R_AW-1:0] res_addr;
  logic [DW-1:0]   res_data;
  logic            res_ovf;
  logic            any_ovf;
  modport master (
    input  start, w_data, a_data, mac_out_in, mac_valid_in, mac_overflow_in,
    output busy, done, w_rd_en, w_addr, a_rd_en, a_addr, mac_en, start_p, last_p,
           weight_out, act_out, res_we, res_addr, res_data, res_ovf, any_ovf
  );
  modport slave (
    output start, w_data, a_data, mac_out_in, mac_valid_in, mac_overflow_in,
    input  busy, done, w_rd_en, w_addr, a_rd_en, a_addr, mac_en, start_p, last_p,
           weight_out, act_out, res_we, res_addr, res_data, res_ovf, any_ovf
  );
endinterface

// File: rtl/npu_tag_pipe.sv
// npu_tag_pipe: fixed-depth shift register aligning {start,last,valid} element tags with downstream latency
module npu_tag_pipe
  import npu_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t d,
  output tag_t q
);
  tag_t pipe [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/npu_mac_seq.sv
// npu_mac_seq: dense-layer sequencer streaming weight/activation pairs into npu_mac and writing one result per neuron
module npu_mac_seq
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH  = NPU_DATA_WIDTH,
  parameter int VEC_LEN     = 16,
  parameter int NUM_NEURONS = 8,
  parameter int W_AW = (VEC_LEN * NUM_NEURONS > 1) ? $clog2(VEC_LEN * NUM_NEURONS) : 1,
  parameter int A_AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
  parameter int R_AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input logic           clk,
  input logic           rst,
  npu_mac_seq_if.master bus
);
  localparam logic [W_AW-1:0] W_LAST = W_AW'(VEC_LEN * NUM_NEURONS - 1);
  localparam logic [A_AW-1:0] K_LAST = A_AW'(VEC_LEN - 1);
  localparam logic [R_AW-1:0] R_LAST = R_AW'(NUM_NEURONS - 1);
  state_t                state, state_n;
  logic [A_AW-1:0]       k;
  logic [W_AW-1:0]       w_cnt;
  logic [R_AW-1:0]       r_cnt, res_addr;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  busy, issue, accept, take, ovf_acc, ovf_cur;
  logic                  res_we, res_ovf, any_ovf, done;
  tag_t                  tag_i, tag_m, tag_o;
  assign busy   = state != IDLE;
  assign issue  = state == ISSUE;
  assign accept = state == IDLE && bus.start;
  assign take   = busy && bus.mac_valid_in;
  assign tag_i  = {issue && k == '0, issue && k == K_LAST, issue};
  npu_tag_pipe #(.DEPTH(1)) mem_align (.clk(clk), .rst(rst), .d(tag_i), .q(tag_m));
  npu_tag_pipe #(.DEPTH(MAC_LATENCY)) ovf_align (.clk(clk), .rst(rst), .d(tag_m), .q(tag_o));
  // the delayed start tag opens a neuron's overflow window; its own step flag is the first term
  assign ovf_cur = tag_o.start ? bus.mac_overflow_in : ovf_acc | (tag_o.valid & bus.mac_overflow_in);
  always_comb
    state_n = accept ? ISSUE
            : (issue && w_cnt == W_LAST) ? DRAIN
            : (state == DRAIN && done) ? IDLE
            : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k        <= '0;
      w_cnt    <= '0;
      r_cnt    <= '0;
      ovf_acc  <= 1'b0;
      res_we   <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
      res_ovf  <= 1'b0;
      any_ovf  <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (issue) begin
        k     <= k == K_LAST ? '0 : k + 1'b1;
        w_cnt <= w_cnt == W_LAST ? '0 : w_cnt + 1'b1;
      end
      ovf_acc <= ovf_cur & ~tag_o.last;
      res_we  <= take;
      done    <= take && r_cnt == R_LAST;
      if (take) begin
        res_addr <= r_cnt;
        res_data <= bus.mac_out_in;
        res_ovf  <= ovf_cur;
        r_cnt    <= r_cnt == R_LAST ? '0 : r_cnt + 1'b1;
      end
      any_ovf <= accept ? 1'b0 : take ? any_ovf | ovf_cur : any_ovf;
    end
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.w_rd_en    = issue;
  assign bus.w_addr     = w_cnt;
  assign bus.a_rd_en    = issue;
  assign bus.a_addr     = k;
  assign bus.mac_en     = tag_m.valid;
  assign bus.start_p    = tag_m.start;
  assign bus.last_p     = tag_m.last;
  assign bus.weight_out = bus.w_data;
  assign bus.act_out    = bus.a_data;
  assign bus.res_we     = res_we;
  assign bus.res_addr   = res_addr;
  assign bus.res_data   = res_data;
  assign bus.res_ovf    = res_ovf;
  assign bus.any_ovf    = any_ovf;
endmodule

// File: tb/tb_npu_mac_seq.sv
// tb_npu_mac_seq: scoreboard bench for npu_mac_seq with ROM and MAC stand-ins, VEC_LEN=4 and VEC_LEN=1 layers of 3 neurons
module tb_npu_mac_seq;
  typedef struct packed {
    logic       busy, done, mac_en, start_p, last_p, res_we;
    logic [1:0] res_addr;
    logic [7:0] res_data;
    logic       res_ovf, any_ovf;
  } obs_t;
  typedef struct {
    int         cyc;
    logic [1:0] addr;
    logic [7:0] data;
    logic       ovf, done;
  } exp_t;

  logic       clk, rst, fin, mon_done, exp_any;
  logic       start_v [2];
  logic [7:0] wmem [2][12];
  logic [7:0] amem [2][4];
  obs_t       obs [2];
  int         cyc, sel, compared, mismatched;
  exp_t       sq [$];
  logic [4:0] fr [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : env
    localparam int L  = g == 0 ? 4 : 1;
    localparam int WA = L * 3 > 1 ? $clog2(L * 3) : 1;
    localparam int AA = L > 1 ? $clog2(L) : 1;
    int         acc, nxt;
    logic       s1_v, s1_o;
    logic [7:0] s1_d;
    npu_mac_seq_if #(.DW(8), .W_AW(WA), .A_AW(AA), .R_AW(2)) bus ();
    npu_mac_seq #(.DATA_WIDTH(8), .VEC_LEN(L), .NUM_NEURONS(3)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    assign bus.start = start_v[g];
    assign obs[g] = {bus.busy, bus.done, bus.mac_en, bus.start_p, bus.last_p, bus.res_we,
                     bus.res_addr, bus.res_data, bus.res_ovf, bus.any_ovf};
    always @(posedge clk or posedge rst)
      if (rst) begin
        bus.w_data <= '0;
        bus.a_data <= '0;
      end else begin
        if (bus.w_rd_en) bus.w_data <= wmem[g][bus.w_addr];
        if (bus.a_rd_en) bus.a_data <= amem[g][bus.a_addr];
      end
    // npu_mac stand-in: unsigned accumulate, Q5 quantise, saturate to 0xFF, two-cycle latency
    assign nxt = (bus.start_p ? 0 : acc) + int'(bus.weight_out) * int'(bus.act_out);
    always @(posedge clk or posedge rst)
      if (rst) begin
        acc <= 0;
        s1_v <= 1'b0;
        s1_o <= 1'b0;
        s1_d <= '0;
        bus.mac_valid_in <= 1'b0;
        bus.mac_overflow_in <= 1'b0;
        bus.mac_out_in <= '0;
      end else begin
        if (bus.mac_en) acc <= nxt;
        s1_v <= bus.mac_en & bus.last_p;
        s1_o <= bus.mac_en & ((nxt >> 5) > 255);
        s1_d <= (nxt >> 5) > 255 ? 8'hFF : 8'(nxt >> 5);
        bus.mac_valid_in <= s1_v;
        bus.mac_overflow_in <= s1_o;
        bus.mac_out_in <= s1_d;
      end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    obs_t       o;
    logic [4:0] f;
    exp_t       e;
    o = obs[sel];
    if (rst) begin
      exp_any = 1'b0;
      check("reset_outputs", 32'(o), 32'd0);
    end else begin
      f = fr.exists(cyc) ? fr[cyc] : 5'd0;
      if (f[3]) exp_any = 1'b0;
      check("busy", o.busy, f[4]);
      check("framing", {o.mac_en, o.start_p, o.last_p}, f[2:0]);
      if (o.res_we) begin
        if (sq.size() == 0) check("unexpected_res_we", o.res_we, 32'd0);
        else begin
          e = sq.pop_front();
          check("res_cycle", cyc, e.cyc);
          check("res_addr", o.res_addr, e.addr);
          check("res_data", o.res_data, e.data);
          check("res_ovf", o.res_ovf, e.ovf);
          check("done", o.done, e.done);
          exp_any = exp_any | e.ovf;
        end
      end else check("done_without_we", o.done, 32'd0);
      check("any_ovf", o.any_ovf, exp_any);
    end
    if (fin && !mon_done) begin
      check("pending_results", sq.size(), 32'd0);
      mon_done = 1'b1;
    end
  end

  function automatic int vlen(input int g);
    return g == 0 ? 4 : 1;
  endfunction

  task automatic fill(input int g, input int mode);
    for (int n = 0; n < 3; n++)
      for (int k = 0; k < vlen(g); k++)
        wmem[g][n*vlen(g)+k] = mode == 0 ? 8'h20 : mode == 1 ? (n == 1 ? 8'h7F : 8'h08) : 8'($urandom_range(0, 90));
    for (int k = 0; k < vlen(g); k++)
      amem[g][k] = mode == 0 ? 8'h10 : mode == 1 ? 8'h7F : 8'($urandom_range(0, 90));
  endtask

  // expected layer: dot products from plain arithmetic, timed by the documented latency
  task automatic launch(input int g);
    int         c0, s, q, idx, l;
    logic [4:0] v;
    exp_t       e;
    l = vlen(g);
    @(posedge clk);
    #1 start_v[g] = 1'b1;
    c0 = cyc;
    for (int c = c0 + 1; c <= c0 + 3 * l + 4; c++) begin
      idx = c - c0 - 2;
      v = {1'b1, c == c0 + 1, 3'b000};
      if (idx >= 0 && idx < 3 * l) v[2:0] = {1'b1, idx % l == 0, idx % l == l - 1};
      fr[c] = v;
    end
    for (int n = 0; n < 3; n++) begin
      s = 0;
      for (int k = 0; k < l; k++) s += int'(wmem[g][n*l+k]) * int'(amem[g][k]);
      q = s >> 5;
      e.cyc = c0 + (n + 1) * l + 4;
      e.addr = 2'(n);
      e.data = q > 255 ? 8'hFF : 8'(q);
      e.ovf = q > 255;
      e.done = n == 2;
      sq.push_back(e);
    end
    @(posedge clk);
    #1 start_v[g] = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && sq.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    sq.delete();
    fr.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    sel = 0;
    fin = 1'b0;
    mon_done = 1'b0;
    exp_any = 1'b0;
    compared = 0;
    mismatched = 0;
    fill(0, 0);
    fill(1, 2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    launch(0);
    wait_done();
    fill(0, 1);
    launch(0);
    wait_done();
    repeat (6) @(posedge clk);
    fill(0, 2);
    launch(0);
    repeat (4) @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    wait_done();
    fill(0, 2);
    launch(0);
    repeat (5) @(posedge clk);
    pulse_rst();
    repeat (20) @(posedge clk);
    launch(0);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      fill(0, 2);
      launch(0);
      wait_done();
    end
    @(posedge clk);
    sel = 1;
    pulse_rst();
    wmem[1][0] = 8'h20;
    wmem[1][1] = 8'h40;
    wmem[1][2] = 8'hE0;
    amem[1][0] = 8'h20;
    launch(1);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      fill(1, 2);
      launch(1);
      wait_done();
    end
    repeat (4) @(posedge clk);
    fin = 1'b1;
    for (int i = 0; i < 5 && !mon_done; i++) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
